// File: rtl/trig_adder_pkg.sv
// Shared encodings for the chunk-serial trigger-gated adder.
package trig_adder_pkg;

   typedef enum logic [1:0] {
      MODE_ADD = 2'b00,
      MODE_SUB = 2'b01,
      MODE_ACC = 2'b10,
      MODE_CLR = 2'b11
   } mode_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/trig_adder_seq_adder_chunk.sv
// One CHUNK-wide slice of the serial adder: purely combinational.
module adder_chunk #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             co
);

   assign {co, s} = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/trig_adder_seq.sv
// Trigger-launched add/sub/accumulate/clear unit; one chunk of the sum per RUN cycle,
// carry held in a register between chunks.
module trig_adder_seq
   import trig_adder_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             trig,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] c,
   output logic             cout,
   output logic             ovf,
   output logic             valid,
   output logic             busy
);

   localparam int STAGES = WIDTH / CHUNK;
   localparam int CW = (STAGES > 1) ? $clog2(STAGES) : 1;
   localparam logic [CW-1:0] LAST = CW'(STAGES - 1);

   state_e           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] part;
   logic [WIDTH-1:0] acc;
   logic             carry;
   logic             is_acc;

   logic [CHUNK-1:0] x;
   logic [CHUNK-1:0] y;
   logic [CHUNK-1:0] s;
   logic             co;
   logic [WIDTH-1:0] full_sum;

   // The chunk adder is time-multiplexed; full_sum merges the current chunk into the partial sum.
   always_comb begin
      x = op_a[cnt*CHUNK +: CHUNK];
      y = op_b[cnt*CHUNK +: CHUNK];
      full_sum = part;
      full_sum[cnt*CHUNK +: CHUNK] = s;
   end

   adder_chunk #(.CHUNK(CHUNK)) u_chunk (
      .x   (x),
      .y   (y),
      .cin (carry),
      .s   (s),
      .co  (co)
   );

   assign busy = (state == ST_RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         op_a   <= '0;
         op_b   <= '0;
         part   <= '0;
         acc    <= '0;
         carry  <= 1'b0;
         is_acc <= 1'b0;
         c      <= '0;
         cout   <= 1'b0;
         ovf    <= 1'b0;
         valid  <= 1'b0;
      end else begin
         valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (trig) begin
                  if (mode == MODE_CLR) begin
                     acc   <= '0;
                     c     <= '0;
                     cout  <= 1'b0;
                     ovf   <= 1'b0;
                     valid <= 1'b1;
                  end else begin
                     // SUB is a + ~b + 1, so the carry register seeds the +1
                     op_a   <= (mode == MODE_ACC) ? acc : a;
                     op_b   <= (mode == MODE_SUB) ? ~b : b;
                     carry  <= (mode == MODE_SUB);
                     is_acc <= (mode == MODE_ACC);
                     cnt    <= '0;
                     part   <= '0;
                     state  <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               part  <= full_sum;
               carry <= co;
               if (cnt == LAST) begin
                  cnt   <= '0;
                  c     <= full_sum;
                  cout  <= co;
                  ovf   <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                           (full_sum[WIDTH-1] != op_a[WIDTH-1]);
                  valid <= 1'b1;
                  state <= ST_IDLE;
                  if (is_acc) begin
                     acc <= full_sum;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_trig_adder_seq.sv
// Self-checking bench for trig_adder_seq: vector table, scoreboard queue, and
// hand-written timing, relaunch and mid-operation reset sequences.
module tb_trig_adder_seq;

   localparam int WIDTH = 32;
   localparam int CHUNK = 8;

   localparam logic [1:0] M_ADD = 2'b00;
   localparam logic [1:0] M_SUB = 2'b01;
   localparam logic [1:0] M_ACC = 2'b10;
   localparam logic [1:0] M_CLR = 2'b11;

   logic             clk;
   logic             rst_n;
   logic             trig;
   logic [1:0]       mode;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] c;
   logic             cout;
   logic             ovf;
   logic             valid;
   logic             busy;

   typedef struct {
      logic [WIDTH-1:0] c;
      logic             cout;
      logic             ovf;
   } exp_t;

   typedef struct {
      logic [1:0]       mode;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] c;
      logic             cout;
      logic             ovf;
   } vec_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   valid_count = 0;

   trig_adder_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .trig  (trig),
      .mode  (mode),
      .a     (a),
      .b     (b),
      .c     (c),
      .cout  (cout),
      .ovf   (ovf),
      .valid (valid),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [WIDTH-1:0] act,
                              input logic [WIDTH-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
      end
   endtask

   // Every valid pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (valid === 1'b1) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_valid: got valid=1 expected no pending op at %0t", $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("c", c, e.c);
            checkOutput("cout", {31'b0, cout}, {31'b0, e.cout});
            checkOutput("ovf", {31'b0, ovf}, {31'b0, e.ovf});
            valid_count++;
         end
      end
   end

   task automatic waitDrain();
      int i;
      for (i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("[TB] FAIL timeout: got %0d pending ops expected 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic applyStimulus(input logic [1:0] m, input logic [WIDTH-1:0] av,
                                input logic [WIDTH-1:0] bv, input logic [WIDTH-1:0] ec,
                                input logic ecout, input logic eovf);
      exp_t e;
      @(negedge clk);
      trig = 1'b1;
      mode = m;
      a    = av;
      b    = bv;
      e.c = ec; e.cout = ecout; e.ovf = eovf;
      sb.push_back(e);
      @(negedge clk);
      trig = 1'b0;
      waitDrain();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t vecs[10];
      exp_t e;
      int   vc0;

      vecs[0] = '{M_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
      vecs[1] = '{M_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
      vecs[2] = '{M_SUB, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0};
      vecs[3] = '{M_SUB, 32'h00000007, 32'h00000005, 32'h00000002, 1'b1, 1'b0};
      vecs[4] = '{M_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1};
      vecs[5] = '{M_CLR, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 1'b0};
      vecs[6] = '{M_ACC, 32'hDEADBEEF, 32'h0000000A, 32'h0000000A, 1'b0, 1'b0};
      vecs[7] = '{M_ACC, 32'hDEADBEEF, 32'h0000000A, 32'h00000014, 1'b0, 1'b0};
      vecs[8] = '{M_ACC, 32'h00000000, 32'h0000000A, 32'h0000001E, 1'b0, 1'b0};
      vecs[9] = '{M_CLR, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0};

      rst_n = 1'b0;
      trig  = 1'b0;
      mode  = M_ADD;
      a     = '0;
      b     = '0;
      repeat (2) @(negedge clk);
      checkOutput("reset_c", c, 32'h0);
      checkOutput("reset_busy", {31'b0, busy}, 32'h0);
      checkOutput("reset_valid", {31'b0, valid}, 32'h0);
      rst_n = 1'b1;

      // Latency: busy for four cycles, valid in the fifth, inter-chunk carry.
      @(negedge clk);
      trig = 1'b1; mode = M_ADD; a = 32'h000000FF; b = 32'h00000001;
      e.c = 32'h00000100; e.cout = 1'b0; e.ovf = 1'b0;
      sb.push_back(e);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 0) trig = 1'b0;
         checkOutput($sformatf("lat_busy%0d", i), {31'b0, busy}, (i < 4) ? 32'd1 : 32'd0);
         checkOutput($sformatf("lat_valid%0d", i), {31'b0, valid}, (i == 4) ? 32'd1 : 32'd0);
      end
      waitDrain();

      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].cout, vecs[i].ovf);
      end

      // CLR completes one cycle after trig without going busy.
      @(negedge clk);
      trig = 1'b1; mode = M_CLR;
      e.c = 32'h0; e.cout = 1'b0; e.ovf = 1'b0;
      sb.push_back(e);
      @(negedge clk);
      trig = 1'b0;
      checkOutput("clr_valid", {31'b0, valid}, 32'd1);
      checkOutput("clr_busy", {31'b0, busy}, 32'd0);
      waitDrain();

      // Held trig relaunches every five cycles; mid-RUN changes to a are ignored.
      vc0 = valid_count;
      @(negedge clk);
      trig = 1'b1; mode = M_ADD; b = 32'd2;
      for (int k = 0; k < 3; k++) begin
         a = 32'(k * 16 + 1);
         e.c = a + 32'd2; e.cout = 1'b0; e.ovf = 1'b0;
         sb.push_back(e);
         repeat (2) @(negedge clk);
         a = 32'hFFFF0000;
         mode = M_SUB;
         repeat (2) @(negedge clk);
         mode = M_ADD;
         @(negedge clk);
         checkOutput($sformatf("relaunch_valid%0d", k), {31'b0, valid}, 32'd1);
         if (k == 2) trig = 1'b0;
      end
      repeat (3) @(negedge clk);
      checkOutput("relaunch_count", 32'(valid_count - vc0), 32'd3);
      waitDrain();

      // Reset during the second RUN cycle discards the operation.
      @(negedge clk);
      trig = 1'b1; mode = M_ADD; a = 32'h11111111; b = 32'h22222222;
      @(negedge clk);
      trig = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("rst_c", c, 32'h0);
      checkOutput("rst_cout", {31'b0, cout}, 32'h0);
      checkOutput("rst_ovf", {31'b0, ovf}, 32'h0);
      checkOutput("rst_valid", {31'b0, valid}, 32'h0);
      checkOutput("rst_busy", {31'b0, busy}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      applyStimulus(M_ADD, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0);

      // Random ADD/SUB against a reference model.
      for (int i = 0; i < 8; i++) begin
         logic [WIDTH-1:0] ra, rb, rbe, rs;
         logic             rc;
         logic [1:0]       rm;
         ra = $urandom;
         rb = $urandom;
         rm = (i % 2 == 0) ? M_ADD : M_SUB;
         rbe = (rm == M_SUB) ? ~rb : rb;
         {rc, rs} = {1'b0, ra} + {1'b0, rbe} + {32'b0, (rm == M_SUB)};
         applyStimulus(rm, ra, rb, rs, rc, (ra[31] == rbe[31]) && (rs[31] != ra[31]));
      end

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
